// File: rtl/ula_pkg.sv
// Shared opcode encoding and default operand width for the ULA.
package ula_pkg;

  localparam int unsigned ULA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_EQ  = 3'b110,
    OP_NEQ = 3'b111
  } opcode_e;

endpackage

// File: rtl/ula_datapath.sv
// Combinational ALU core: next result plus carry/zero/overflow flags.
// Flags are computed only when ULA_FLAGS_EN is defined; otherwise they are constant 0.
module ula_datapath
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  always_comb begin
    result = '0;
    case (opcode_e'(opcode))
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_NEQ: result = {{(WIDTH-1){1'b0}}, (a != b)};
      default: result = '0;
    endcase
  end

`ifdef ULA_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // Bit WIDTH of the widened difference is the unsigned borrow (a < b).
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: begin
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        carry    = diff_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);
`else
  assign carry    = 1'b0;
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/ula_8bit.sv
// Registered ALU top: one-cycle latency result and flags, async active-high reset.
// Optional flag generation is enabled by defining ULA_FLAGS_EN.
module ula_8bit
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] s_d, s_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  ula_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (s_d),
    .carry    (carry_d),
    .zero     (zero_d),
    .overflow (overflow_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign s        = s_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ula_8bit.sv
// Self-checking bench for ula_8bit: directed table, reset/back-to-back sequences, random vectors.
module tb_ula_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [7:0] s;
  logic       carry;
  logic       zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ula_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .s        (s),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] es,
                           input logic ec, input logic ez, input logic ev);
    check({name, ".s"}, s, es);
`ifdef ULA_FLAGS_EN
    check({name, ".carry"}, {7'd0, carry}, {7'd0, ec});
    check({name, ".zero"}, {7'd0, zero}, {7'd0, ez});
    check({name, ".ovf"}, {7'd0, overflow}, {7'd0, ev});
`else
    check({name, ".carry"}, {7'd0, carry}, 8'd0);
    check({name, ".zero"}, {7'd0, zero}, 8'd0);
    check({name, ".ovf"}, {7'd0, overflow}, 8'd0);
    if (ec || ez || ev) begin end
`endif
  endtask

  // Reference model in plain integer arithmetic, 8-bit operands.
  function automatic void model(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                                output logic [7:0] rs, output logic rc, output logic rz,
                                output logic rv);
    int ua, ub, sa, sb, r, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r  = 0;
    rc = 1'b0;
    rv = 1'b0;
    case (op)
      3'd0: begin
        r  = (ua + ub) % 256;
        rc = (ua + ub) > 255;
        sr = sa + sb;
        rv = (sr > 127) || (sr < -128);
      end
      3'd1: begin
        r  = (ua - ub + 256) % 256;
        rc = ua < ub;
        sr = sa - sb;
        rv = (sr > 127) || (sr < -128);
      end
      3'd2: r = int'(ia & ib);
      3'd3: r = int'(ia | ib);
      3'd4: r = int'(ia ^ ib);
      3'd5: r = 255 - ua;
      3'd6: r = (ua == ub) ? 1 : 0;
      default: r = (ua != ub) ? 1 : 0;
    endcase
    rs = 8'(r);
    rz = (r == 0);
  endfunction

  task automatic apply(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib);
    @(negedge clk);
    opcode = op;
    a      = ia;
    b      = ib;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] es;
  logic       ec, ez, ev;
  logic [7:0] prev_s;
  logic       prev_c, prev_z, prev_v;

  initial begin
    vecs[0]  = '{3'd0, 8'h05, 8'h0A, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'h0F, 8'h0A, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd2, 8'hCA, 8'hAC, 8'h88, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'hCA, 8'hAC, 8'hEE, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 8'hCA, 8'hAC, 8'h66, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd5, 8'hF0, 8'h33, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 8'h0A, 8'h0A, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 8'h05, 8'h0A, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd7, 8'h0A, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};

    rst    = 1'b1;
    a      = 8'h12;
    b      = 8'h34;
    opcode = 3'd0;
    #1;
    check_all("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].z, vecs[i].v);
    end

    // Reset between edges discards the pending ADD 3+4.
    apply(3'd1, 8'h00, 8'h01);
    check_all("sub_wrap", 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    opcode = 3'd0;
    a      = 8'h03;
    b      = 8'h04;
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_mid_imm", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("rst_hold%0d", k), 8'h00, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("rst_release", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("post_rst", 8'h07, 1'b0, 1'b0, 1'b0);

    // Back-to-back opcode sweep: result must still hold the previous op until the edge.
    model(3'd0, 8'h03, 8'h04, prev_s, prev_c, prev_z, prev_v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_all($sformatf("b2b_hold%0d", i), prev_s, prev_c, prev_z, prev_v);
      opcode = 3'(i);
      a      = 8'h9C;
      b      = 8'h3B;
      @(posedge clk);
      #1;
      model(3'(i), 8'h9C, 8'h3B, es, ec, ez, ev);
      check_all($sformatf("b2b_op%0d", i), es, ec, ez, ev);
      prev_s = es;
      prev_c = ec;
      prev_z = ez;
      prev_v = ev;
    end

    for (int n = 0; n < 300; n++) begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      apply(rop, ra, rb);
      model(rop, ra, rb, es, ec, ez, ev);
      check_all($sformatf("rand%0d_op%0d_%02h_%02h", n, rop, ra, rb), es, ec, ez, ev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
